// File: rtl/wb_if.sv
// wb_if -- result/write-back bus between the retiring pipeline stage and
// the register file, as seen by wb_stage.
//   master : upstream producer + register-file side (drives i_*, samples o_*)
//   slave  : wb_stage itself
// Signals (names are from the write-back stage's point of view):
//   i_valid, o_ready              accept handshake
//   i_opcode, i_funct3, i_addr_lo retiring instruction decode / load lane
//   i_rd, i_alu_result, i_load_data
//   i_rf_stall                    register-file port busy this cycle
//   o_rf_wr, o_rf_rd, o_rf_data   register-file write port
//   o_busy                        buffer non-empty (hazard unit)
interface wb_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) ();
  logic            i_valid;
  logic            o_ready;
  logic [6:0]      i_opcode;
  logic [2:0]      i_funct3;
  logic [1:0]      i_addr_lo;
  logic [RA_W-1:0] i_rd;
  logic [XLEN-1:0] i_alu_result;
  logic [XLEN-1:0] i_load_data;
  logic            i_rf_stall;
  logic            o_rf_wr;
  logic [RA_W-1:0] o_rf_rd;
  logic [XLEN-1:0] o_rf_data;
  logic            o_busy;

  modport master (
    output i_valid, i_opcode, i_funct3, i_addr_lo, i_rd,
           i_alu_result, i_load_data, i_rf_stall,
    input  o_ready, o_rf_wr, o_rf_rd, o_rf_data, o_busy
  );

  modport slave (
    input  i_valid, i_opcode, i_funct3, i_addr_lo, i_rd,
           i_alu_result, i_load_data, i_rf_stall,
    output o_ready, o_rf_wr, o_rf_rd, o_rf_data, o_busy
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage -- write-back stage with a small FIFO buffer in front of the
// register-file write port.  Results are formatted (write enable, load
// extraction / sign extension) when accepted and stored at the tail; the
// head retires whenever the register file is not stalled.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (drops all buffered entries)
//   bus        wb_if.slave: handshake, instruction fields, rf write port
//   o_instret  64-bit retire counter, present only with WB_INSTRET_EN
// Optional feature macro: WB_INSTRET_EN (retired-instruction counter).
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int RA_W  = 5
) (
  input  logic        clk,
  input  logic        rst,
`ifdef WB_INSTRET_EN
  output logic [63:0] o_instret,
`endif
  wb_if.slave         bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL     = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ZERO = {(PW+1){1'b0}};
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Write enable: no architectural destination for branch/store/fence or x0.
  function automatic logic fmt_we(input logic [6:0] op, input logic [RA_W-1:0] rd);
    logic we;
    case (op)
      OP_BRANCH, OP_STORE, OP_FENCE: we = 1'b0;
      default:                       we = (rd != {RA_W{1'b0}});
    endcase
    return we;
  endfunction

  // Result formatting.  The load word is shifted down by the byte offset
  // first, so a half-word load at offset 3 sees byte 3 with zeros above it
  // and therefore always comes out zero-extended.
  function automatic logic [XLEN-1:0] fmt_data(
    input logic [6:0]      op,
    input logic [2:0]      f3,
    input logic [1:0]      lo,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] ld
  );
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = ld >> {lo, 3'b000};
    if (op == OP_LOAD) begin
      case (f3)
        3'b000:  res = {{(XLEN-8){sh[7]}}, sh[7:0]};
        3'b001:  res = {{(XLEN-16){sh[15]}}, sh[15:0]};
        3'b010:  res = sh;
        3'b100:  res = {{(XLEN-8){1'b0}}, sh[7:0]};
        3'b101:  res = {{(XLEN-16){1'b0}}, sh[15:0]};
        default: res = {XLEN{1'b0}};
      endcase
    end else begin
      res = alu;
    end
    return res;
  endfunction

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            we_mem   [DEPTH];
  logic [RA_W-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  logic accept;
  logic retire;
  logic head_wr;

  // Handshake and retire decisions; o_ready looks only at the registered
  // count, so a full buffer never accepts even while it retires.
  always_comb begin
    accept = bus.i_valid & bus.o_ready;
    retire = (count != CNT_ZERO) & ~bus.i_rf_stall;
  end

  assign bus.o_ready = (count != FULL);
  assign bus.o_busy  = (count != CNT_ZERO);

  // Pointer and occupancy bookkeeping; reset wins over accept/retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= PTR_ZERO;
      rd_ptr <= PTR_ZERO;
      count  <= CNT_ZERO;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (retire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({accept, retire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: the formatted result is written at the tail on accept.
  // Contents need no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_mem[wr_ptr]   <= fmt_we(bus.i_opcode, bus.i_rd);
      rd_mem[wr_ptr]   <= bus.i_rd;
      data_mem[wr_ptr] <= fmt_data(bus.i_opcode, bus.i_funct3, bus.i_addr_lo,
                                   bus.i_alu_result, bus.i_load_data);
    end
  end

  // Register-file write port; address/data forced to zero when not writing.
  // rst also masks the write so the reset cycle itself never writes.
  always_comb begin
    head_wr = ~rst & (count != CNT_ZERO) & we_mem[rd_ptr] & ~bus.i_rf_stall;
    bus.o_rf_wr = head_wr;
    if (head_wr) begin
      bus.o_rf_rd   = rd_mem[rd_ptr];
      bus.o_rf_data = data_mem[rd_ptr];
    end else begin
      bus.o_rf_rd   = {RA_W{1'b0}};
      bus.o_rf_data = {XLEN{1'b0}};
    end
  end

`ifdef WB_INSTRET_EN
  logic [63:0] instret;

  // Retire counter: counts every popped entry, including non-writing ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= 64'd0;
    end else if (retire) begin
      instret <= instret + 64'd1;
    end else begin
      instret <= instret;
    end
  end

  assign o_instret = instret;
`endif
endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int RA_W  = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

`ifdef WB_INSTRET_EN
  logic [63:0] instret;
  logic [63:0] exp_instret = 64'd0;
`endif

  wb_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .RA_W(RA_W)) dut (
    .clk       (clk),
`ifdef WB_INSTRET_EN
    .o_instret (instret),
`endif
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every negedge, pop/compare on a write, else outputs must be zero.
  always @(negedge clk) begin
    if (bus.o_rf_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write",
                 bus.o_rf_rd, bus.o_rf_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", 64'(bus.o_rf_rd), 64'(e.rd));
        chk("wb_data", 64'(bus.o_rf_data), 64'(e.data));
      end
    end else begin
      chk("idle_wr_known", 64'(bus.o_rf_wr), 64'd0);
      chk("idle_rd_zero", 64'(bus.o_rf_rd), 64'd0);
      chk("idle_data_zero", 64'(bus.o_rf_data), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] lo,
                       input logic [RA_W-1:0] rd, input logic [XLEN-1:0] alu,
                       input logic [XLEN-1:0] ld);
    bus.i_valid      = 1'b1;
    bus.i_opcode     = op;
    bus.i_funct3     = f3;
    bus.i_addr_lo    = lo;
    bus.i_rd         = rd;
    bus.i_alu_result = alu;
    bus.i_load_data  = ld;
  endtask

  // Hold the driven op until accepted; push the expected write at acceptance.
  task automatic wait_accept(input logic we, input logic [RA_W-1:0] rd, input logic [XLEN-1:0] data);
    logic rdy;
    bit   done;
    exp_t e;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = bus.o_ready;
      @(posedge clk);
      if (rdy) begin
        done = 1'b1;
        if (we) begin
          e.rd   = rd;
          e.data = data;
          exp_q.push_back(e);
        end
      end
    end
    #1;
    bus.i_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end
`ifdef WB_INSTRET_EN
    else exp_instret = exp_instret + 64'd1;
`endif
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] lo,
                      input logic [RA_W-1:0] rd, input logic [XLEN-1:0] alu,
                      input logic [XLEN-1:0] ld, input logic we, input logic [XLEN-1:0] data);
    drive(op, f3, lo, rd, alu, ld);
    wait_accept(we, rd, data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid      = 1'b0;
    bus.i_opcode     = 7'd0;
    bus.i_funct3     = 3'd0;
    bus.i_addr_lo    = 2'd0;
    bus.i_rd         = 5'd0;
    bus.i_alu_result = 32'd0;
    bus.i_load_data  = 32'd0;
    bus.i_rf_stall   = 1'b0;
    rst              = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 64'(bus.o_ready), 64'd1);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_wr", 64'(bus.o_rf_wr), 64'd0);
`ifdef WB_INSTRET_EN
    chk("rst_instret", instret, 64'd0);
`endif
    tick();

    // LW, one-cycle latency
    send(OP_LOAD, 3'b010, 2'b00, 5'd5, 32'h0, 32'h8000_00F0, 1'b1, 32'h8000_00F0);
    @(negedge clk);
    chk("lw_latency_wr", 64'(bus.o_rf_wr), 64'd1);
    tick();

    // Load formatting vectors, back to back
    send(OP_LOAD, 3'b000, 2'b11, 5'd6,  32'h0, 32'h8012_3456, 1'b1, 32'hFFFF_FF80);
    send(OP_LOAD, 3'b100, 2'b11, 5'd7,  32'h0, 32'h8012_3456, 1'b1, 32'h0000_0080);
    send(OP_LOAD, 3'b001, 2'b10, 5'd8,  32'h0, 32'h8001_ABCD, 1'b1, 32'hFFFF_8001);
    send(OP_LOAD, 3'b101, 2'b10, 5'd9,  32'h0, 32'h8001_ABCD, 1'b1, 32'h0000_8001);
    send(OP_LOAD, 3'b001, 2'b11, 5'd10, 32'h0, 32'h8055_1234, 1'b1, 32'h0000_0080);
    send(OP_LOAD, 3'b000, 2'b01, 5'd11, 32'h0, 32'h0000_7F00, 1'b1, 32'h0000_007F);
    send(OP_LOAD, 3'b011, 2'b00, 5'd12, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
    send(OP_IMM,  3'b000, 2'b00, 5'd13, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF);
    send(OP_REG,  3'b000, 2'b00, 5'd31, 32'h0000_0042, 32'h0, 1'b1, 32'h0000_0042);

    // Non-writing ops still retire
    send(OP_STORE,  3'b010, 2'b00, 5'd3, 32'h1111_1111, 32'h0, 1'b0, 32'h0);
    send(OP_BRANCH, 3'b000, 2'b00, 5'd4, 32'h2222_2222, 32'h0, 1'b0, 32'h0);
    send(OP_REG,    3'b000, 2'b00, 5'd0, 32'h3333_3333, 32'h0, 1'b0, 32'h0);
    send(OP_FENCE,  3'b000, 2'b00, 5'd4, 32'h4444_4444, 32'h0, 1'b0, 32'h0);
    repeat (3) tick();
    @(negedge clk);
    chk("nowrite_drained_busy", 64'(bus.o_busy), 64'd0);
`ifdef WB_INSTRET_EN
    chk("instret_count", instret, exp_instret);
`endif
    tick();

    // Stall: fill to DEPTH, third op waits for first retire
    bus.i_rf_stall = 1'b1;
    send(OP_REG, 3'b000, 2'b00, 5'd1, 32'h0000_0011, 32'h0, 1'b1, 32'h0000_0011);
    send(OP_REG, 3'b000, 2'b00, 5'd2, 32'h0000_0022, 32'h0, 1'b1, 32'h0000_0022);
    @(negedge clk);
    chk("full_ready", 64'(bus.o_ready), 64'd0);
    chk("full_busy", 64'(bus.o_busy), 64'd1);
    tick();
    drive(OP_REG, 3'b000, 2'b00, 5'd3, 32'h0000_0033, 32'h0);
    @(negedge clk);
    chk("full_ready_held", 64'(bus.o_ready), 64'd0);
    tick();
    bus.i_rf_stall = 1'b0;
    wait_accept(1'b1, 5'd3, 32'h0000_0033);
    repeat (3) tick();
    @(negedge clk);
    chk("stall_drained_busy", 64'(bus.o_busy), 64'd0);
    chk("stall_drained_q", 64'(exp_q.size()), 64'd0);
    tick();

    // Reset mid-operation discards a full buffer
    bus.i_rf_stall = 1'b1;
    send(OP_REG, 3'b000, 2'b00, 5'd20, 32'h0000_00A0, 32'h0, 1'b1, 32'h0000_00A0);
    send(OP_REG, 3'b000, 2'b00, 5'd21, 32'h0000_00A1, 32'h0, 1'b1, 32'h0000_00A1);
    @(negedge clk);
    chk("prerst_busy", 64'(bus.o_busy), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    bus.i_rf_stall = 1'b0;
`ifdef WB_INSTRET_EN
    exp_instret = 64'd0;
`endif
    repeat (4) tick();
    @(negedge clk);
    chk("postrst_busy", 64'(bus.o_busy), 64'd0);
    chk("postrst_ready", 64'(bus.o_ready), 64'd1);
`ifdef WB_INSTRET_EN
    chk("postrst_instret", instret, 64'd0);
`endif
    tick();

`ifdef WB_INSTRET_EN
    // Counter wrap
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFE;
    @(negedge clk);
    release dut.instret;
    tick();
    send(OP_REG, 3'b000, 2'b00, 5'd14, 32'h5, 32'h0, 1'b1, 32'h5);
    send(OP_STORE, 3'b000, 2'b00, 5'd0, 32'h6, 32'h0, 1'b0, 32'h0);
    repeat (3) tick();
    @(negedge clk);
    chk("instret_wrap", instret, 64'd0);
    tick();
`endif

    // Post-reset traffic still works
    send(OP_LOAD, 3'b010, 2'b00, 5'd15, 32'h0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);
    repeat (3) tick();
    @(negedge clk);
    chk("final_q_empty", 64'(exp_q.size()), 64'd0);
    chk("final_busy", 64'(bus.o_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width of results and register-file write data.
REQ-002 SHALL have parameter DEPTH, default 2: write-back buffer entries; power of two, minimum 2.
REQ-003 SHALL have parameter RA_W, default 5: register-address width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 i_valid  input  1  upstream result valid.
REQ-007 o_ready  output  1  buffer can accept; equals (count != DEPTH).
REQ-008 i_opcode  input  7  RV32 opcode of the retiring instruction.
REQ-009 i_funct3  input  3  load size/sign select.
REQ-010 i_addr_lo  input  2  low address bits of the load.
REQ-011 i_rd  input  RA_W  destination register.
REQ-012 i_alu_result  input  XLEN  non-load result.
REQ-013 i_load_data  input  XLEN  raw aligned-word load data.
REQ-014 i_rf_stall  input  1  register-file port busy; no retire this cycle.
REQ-015 o_rf_wr  output  1  register-file write enable.
REQ-016 o_rf_rd  output  RA_W  register-file write address.
REQ-017 o_rf_data  output  XLEN  register-file write data.
REQ-018 o_busy  output  1  buffer non-empty (hazard-unit input).

Function
REQ-019 Accept occurs when i_valid and o_ready are both 1; accepted instruction SHALL be formatted and stored at the tail in that cycle.
REQ-020 Write-enable formatting: we = 0 for opcodes 1100011 (branch), 0100011 (store), 0001111 (fence), or i_rd == 0; otherwise 1.
REQ-021 Data formatting: opcode 0000011 (load) selects i_load_data shifted right by 8*i_addr_lo, then funct3 000 LB sign-extend byte, 001 LH sign-extend half, 010 LW full word, 100 LBU zero-extend byte, 101 LHU zero-extend half; other funct3 yields 0; non-load selects i_alu_result.
REQ-022 LH/LHU with i_addr_lo = 11 SHALL use the byte at bits [31:24] zero-extended in the upper half-byte lane (misalignment is trapped upstream; result is don't-care-free and deterministic).
REQ-023 Head entry retires (pops) in any cycle with count != 0 and i_rf_stall == 0.
REQ-024 o_rf_wr = head valid & head we & !i_rf_stall; o_rf_rd and o_rf_data SHALL be 0 whenever o_rf_wr == 0.
REQ-025 Latency: an instruction accepted in cycle N into an empty buffer SHALL drive o_rf_wr in cycle N+1 if unstalled; no same-cycle pass-through.
REQ-026 Simultaneous accept and retire SHALL leave count unchanged; while full, accept is blocked even if retiring the same cycle (o_ready depends on registered count only).
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; order is strict FIFO.
REQ-028 i_valid while o_ready == 0 SHALL be ignored; upstream holds its data.
REQ-029 o_busy = (count != 0).

Reset
REQ-030 rst == 1 at a clock edge SHALL clear pointers, count, and instret counter; outputs become o_ready=1, o_rf_wr=0, o_rf_rd=0, o_rf_data=0, o_busy=0.
REQ-031 rst asserted mid-operation SHALL discard all buffered entries with no register-file write in that or following cycles; rst has priority over accept and retire.

Configuration
REQ-032 Macro WB_INSTRET_EN: when defined, adds output o_instret (64 bits), incremented by 1 on every retire (including we = 0 entries), wrapping from 2^64-1 to 0, cleared by rst.
REQ-033 Without WB_INSTRET_EN, o_instret port and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-034 Reset then LW, rd=5, load_data 0x8000_00F0, addr_lo 00 -> next cycle o_rf_wr=1, rd=5, data 0x8000_00F0.
REQ-035 LB addr_lo 11, load_data 0x80xx_xxxx -> data 0xFFFF_FF80; LBU same -> 0x0000_0080; LH addr_lo 10, 0x8001_xxxx -> 0xFFFF_8001.
REQ-036 Store, branch, and ALU op with rd=0 -> o_rf_wr=0, o_rf_data=0, entries still retire (instret +3 with WB_INSTRET_EN).
REQ-037 Hold i_rf_stall=1, send 3 valid ops (DEPTH=2) -> o_ready=0 after 2 accepts; release stall -> writes in order, one per cycle, third accepted after first retire.
REQ-038 Fill buffer with 2 writing ops, assert rst one cycle -> no o_rf_wr afterwards, o_busy=0, o_ready=1.
REQ-039 WB_INSTRET_EN, preload counter near 2^64-1 via retires/force -> wraps to 0.
